// File: rtl/i2c_eeprom_slave_if.sv
// Bus bundle between an I2C EEPROM target and its environment: line levels,
// write protect, SDA drive enable and the memory-commit / pointer observation taps.
interface i2c_eeprom_slave_if #(
  parameter int unsigned MEM_AW = 8
);
  logic              scl_in;
  logic              sda_in;
  logic              wp_pin;
  logic              sda_oen;
  logic              busy;
  logic              mem_wr;
  logic [MEM_AW-1:0] mem_wr_addr;
  logic [7:0]        mem_wr_data;
  logic [MEM_AW-1:0] addr_ptr;

  modport slave (
    input  scl_in, sda_in, wp_pin,
    output sda_oen, busy, mem_wr, mem_wr_addr, mem_wr_data, addr_ptr
  );

  modport master (
    output scl_in, sda_in, wp_pin,
    input  sda_oen, busy, mem_wr, mem_wr_addr, mem_wr_data, addr_ptr
  );
endinterface

// File: rtl/i2c_eeprom_slave.sv
// 24Cxx-style I2C EEPROM target with 16-bit word addressing, page-wrapped writes,
// sequential reads and a write-cycle busy window that NACKs the device address.
module i2c_eeprom_slave #(
  parameter logic [6:0]  DEV_ADDR   = 7'b1010111,
  parameter int unsigned MEM_AW     = 8,
  parameter int unsigned PAGE_AW    = 5,
  parameter int unsigned TWR_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  i2c_eeprom_slave_if.slave bus
);

  localparam int unsigned       CntW     = $clog2(TWR_CYCLES + 1);
  localparam logic [MEM_AW-1:0] PageMask = MEM_AW'((64'd1 << PAGE_AW) - 64'd1);

  typedef enum logic [2:0] {StIdle, StDev, StWah, StWal, StWd, StRd} state_e;

  state_e            r_state;
  state_e            r_next;
  logic [1:0]        r_scl_sync;
  logic [1:0]        r_sda_sync;
  logic              r_scl_d;
  logic              r_sda_d;
  logic [3:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic [7:0]        r_addr_hi;
  logic              r_pending;
  logic              r_busy;
  logic [CntW-1:0]   r_busy_cnt;
  logic              r_sda_oen;
  logic              r_mem_wr;
  logic [MEM_AW-1:0] r_mem_wr_addr;
  logic [7:0]        r_mem_wr_data;
  logic [MEM_AW-1:0] r_addr_ptr;
  logic [7:0]        r_mem [2**MEM_AW];

  logic              w_scl;
  logic              w_sda;
  logic              w_scl_rise;
  logic              w_scl_fall;
  logic              w_start;
  logic              w_stop;
  logic [7:0]        w_byte;
  logic [7:0]        w_rd_byte;
  logic [MEM_AW-1:0] w_ptr_page_inc;

  assign w_scl      = r_scl_sync[1];
  assign w_sda      = r_sda_sync[1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SCL held high across both samples isolates data-line transitions as bus conditions
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_rd_byte  = r_mem[r_addr_ptr];
  // Only the in-page offset advances; the page base stays put
  assign w_ptr_page_inc = (r_addr_ptr & ~PageMask) | ((r_addr_ptr + MEM_AW'(1)) & PageMask);

  assign bus.sda_oen     = r_sda_oen;
  assign bus.busy        = r_busy;
  assign bus.mem_wr      = r_mem_wr;
  assign bus.mem_wr_addr = r_mem_wr_addr;
  assign bus.mem_wr_data = r_mem_wr_data;
  assign bus.addr_ptr    = r_addr_ptr;

  // Protocol FSM: synchronizers, bus conditions, byte shifting, ACK slots, busy timer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_next        <= StIdle;
      r_scl_sync    <= 2'b11;
      r_sda_sync    <= 2'b11;
      r_scl_d       <= 1'b1;
      r_sda_d       <= 1'b1;
      r_bit_cnt     <= 4'd0;
      r_shift       <= 8'h00;
      r_addr_hi     <= 8'h00;
      r_pending     <= 1'b0;
      r_busy        <= 1'b0;
      r_busy_cnt    <= '0;
      r_sda_oen     <= 1'b1;
      r_mem_wr      <= 1'b0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= 8'h00;
      r_addr_ptr    <= '0;
    end else begin
      r_scl_sync <= {r_scl_sync[0], bus.scl_in};
      r_sda_sync <= {r_sda_sync[0], bus.sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      r_mem_wr   <= 1'b0;

      if (r_busy) begin
        if (r_busy_cnt == '0) r_busy <= 1'b0;
        else                  r_busy_cnt <= r_busy_cnt - CntW'(1);
      end

      if (w_stop) begin
        r_state   <= StIdle;
        r_sda_oen <= 1'b1;
        if (r_pending) begin
          r_busy     <= 1'b1;
          r_busy_cnt <= CntW'(TWR_CYCLES - 1);
          r_pending  <= 1'b0;
        end
      end else if (w_start) begin
        // Repeated START abandons the write cycle; committed bytes stay committed
        r_state   <= StDev;
        r_bit_cnt <= 4'd0;
        r_sda_oen <= 1'b1;
        r_pending <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: ;
          StDev, StWah, StWal, StWd: begin
            if (w_scl_rise && r_bit_cnt < 4'd8) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                case (r_state)
                  StDev: begin
                    if (w_byte[7:1] == DEV_ADDR && !r_busy) r_next  <= w_byte[0] ? StRd : StWah;
                    else                                     r_state <= StIdle;
                  end
                  StWah: begin
                    r_addr_hi <= w_byte;
                    r_next    <= StWal;
                  end
                  StWal: begin
                    r_addr_ptr <= MEM_AW'({r_addr_hi, w_byte});
                    r_next     <= StWd;
                  end
                  StWd: begin
                    if (!bus.wp_pin) begin
                      r_mem_wr      <= 1'b1;
                      r_mem_wr_addr <= r_addr_ptr;
                      r_mem_wr_data <= w_byte;
                      r_pending     <= 1'b1;
                    end
                    r_addr_ptr <= w_ptr_page_inc;
                    r_next     <= StWd;
                  end
                  default: ;
                endcase
              end
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_sda_oen <= 1'b0;
              r_bit_cnt <= 4'd9;
            end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
              r_sda_oen <= 1'b1;
              r_bit_cnt <= 4'd0;
              r_state   <= r_next;
              if (r_next == StRd) begin
                r_shift    <= w_rd_byte;
                r_sda_oen  <= w_rd_byte[7];
                r_addr_ptr <= r_addr_ptr + MEM_AW'(1);
              end
            end
          end
          StRd: begin
            if (w_scl_rise) begin
              if (r_bit_cnt < 4'd8) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end else if (r_bit_cnt == 4'd8) begin
                // Master ACK slot: NACK ends the read
                if (w_sda) r_state <= StIdle;
                else       r_bit_cnt <= 4'd9;
              end
            end else if (w_scl_fall) begin
              if (r_bit_cnt >= 4'd1 && r_bit_cnt <= 4'd7) begin
                r_shift   <= {r_shift[6:0], r_shift[7]};
                r_sda_oen <= r_shift[6];
              end else if (r_bit_cnt == 4'd8) begin
                r_sda_oen <= 1'b1;
              end else if (r_bit_cnt == 4'd9) begin
                r_shift    <= w_rd_byte;
                r_sda_oen  <= w_rd_byte[7];
                r_addr_ptr <= r_addr_ptr + MEM_AW'(1);
                r_bit_cnt  <= 4'd0;
              end
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Memory array write port, fed by the registered commit pulse; contents survive reset
  always_ff @(posedge clk) begin
    if (r_mem_wr) r_mem[r_mem_wr_addr] <= r_mem_wr_data;
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bit-banged I2C master, table of byte writes,
// hand-written read / page-wrap / busy / reset sequences, queue-based scoreboard.
module tb_i2c_eeprom_slave;

  localparam int unsigned MEM_AW = 8;
  localparam int          Q      = 4;

  typedef struct {
    logic [15:0] word_addr;
    logic [7:0]  data;
    logic        wp;
    logic        exp_commit;
    logic [7:0]  exp_wr_addr;
    logic [7:0]  exp_ptr;
  } wr_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic wp = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int busy_run = 0;
  int busy_last = 0;

  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  wr_vec_t     vecs [7];

  i2c_eeprom_slave_if #(.MEM_AW(MEM_AW)) bus ();

  assign bus.scl_in = scl;
  assign bus.sda_in = sda_m & bus.sda_oen;
  assign bus.wp_pin = wp;

  i2c_eeprom_slave #(
    .DEV_ADDR  (7'b1010111),
    .MEM_AW    (MEM_AW),
    .PAGE_AW   (5),
    .TWR_CYCLES(50000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Commit monitor: every mem_wr pulse must match the oldest expected commit
  always @(negedge clk) begin
    if (bus.mem_wr === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mem_wr_unexpected: got addr 0x%0h data 0x%0h, expected no write",
                 bus.mem_wr_addr, bus.mem_wr_data);
      end else begin
        logic [15:0] e;
        e = exp_wr_q.pop_front();
        check("mem_wr_addr", 32'(bus.mem_wr_addr), 32'(e[15:8]));
        check("mem_wr_data", 32'(bus.mem_wr_data), 32'(e[7:0]));
      end
    end
  end

  // Busy pulse width measurement
  always @(negedge clk) begin
    if (bus.busy === 1'b1) busy_run++;
    else if (busy_run != 0) begin
      busy_last = busy_run;
      busy_run  = 0;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl   = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl   = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic bit_out(input logic b);
    sda_m = b;    tick(Q);
    scl   = 1'b1; tick(2 * Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic bit_in(output logic v);
    sda_m = 1'b1; tick(Q);
    scl   = 1'b1; tick(Q);
    v     = bus.sda_in; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack_n);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    bit_in(ack_n);
  endtask

  task automatic read_byte(input logic master_nack, output logic [7:0] v);
    for (int i = 7; i >= 0; i--) bit_in(v[i]);
    bit_out(master_nack);
  endtask

  task automatic i2c_write(input logic [15:0] a, input int n,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    logic ack_n;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hAE, ack_n); check("wr_ack_dev", 32'(ack_n), 32'd0);
    write_byte(a[15:8], ack_n); check("wr_ack_ahi", 32'(ack_n), 32'd0);
    write_byte(a[7:0], ack_n); check("wr_ack_alo", 32'(ack_n), 32'd0);
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : (i == 1) ? d1 : d2;
      write_byte(d, ack_n); check("wr_ack_data", 32'(ack_n), 32'd0);
    end
    i2c_stop();
  endtask

  // Dummy write + repeated START + sequential read; last byte gets a master NACK
  task automatic i2c_rand_read(input logic [15:0] a, input int n);
    logic ack_n;
    logic [7:0] v;
    logic [7:0] e;
    i2c_start();
    write_byte(8'hAE, ack_n); check("rd_ack_dev_w", 32'(ack_n), 32'd0);
    write_byte(a[15:8], ack_n); check("rd_ack_ahi", 32'(ack_n), 32'd0);
    write_byte(a[7:0], ack_n); check("rd_ack_alo", 32'(ack_n), 32'd0);
    i2c_start();
    write_byte(8'hAF, ack_n); check("rd_ack_dev_r", 32'(ack_n), 32'd0);
    for (int i = 0; i < n; i++) begin
      read_byte((i == n - 1), v);
      if (exp_rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_data_unexpected: got 0x%0h, expected none", v);
      end else begin
        e = exp_rd_q.pop_front();
        check("rd_data", 32'(v), 32'(e));
      end
    end
    i2c_stop();
  endtask

  task automatic probe(output logic ack_n);
    i2c_start();
    write_byte(8'hAE, ack_n);
    i2c_stop();
  endtask

  task automatic pulse_rst();
    rst = 1'b1; tick(2);
    rst = 1'b0; tick(2);
  endtask

  initial begin
    logic ack_n;
    logic [7:0] v;

    vecs[0] = '{16'h0020, 8'h11, 1'b0, 1'b1, 8'h20, 8'h21};
    vecs[1] = '{16'h0021, 8'h22, 1'b0, 1'b1, 8'h21, 8'h22};
    vecs[2] = '{16'h0022, 8'h33, 1'b0, 1'b1, 8'h22, 8'h23};
    vecs[3] = '{16'h0040, 8'h3C, 1'b0, 1'b1, 8'h40, 8'h41};
    vecs[4] = '{16'h0040, 8'h77, 1'b1, 1'b0, 8'h00, 8'h41};
    vecs[5] = '{16'hFF55, 8'hA5, 1'b0, 1'b1, 8'h55, 8'h56};
    vecs[6] = '{16'h00FF, 8'h99, 1'b0, 1'b1, 8'hFF, 8'hE0};

    // Reset state
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_sda_oen", 32'(bus.sda_oen), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("rst_mem_wr_addr", 32'(bus.mem_wr_addr), 32'd0);
    check("rst_mem_wr_data", 32'(bus.mem_wr_data), 32'd0);
    check("rst_addr_ptr", 32'(bus.addr_ptr), 32'd0);
    tick(4);

    // Byte write, then busy window
    exp_wr_q.push_back({8'h10, 8'h5A});
    i2c_write(16'h0010, 1, 8'h5A, 8'h00, 8'h00);
    tick(2);
    check("t1_busy_set", 32'(bus.busy), 32'd1);
    check("t1_ptr", 32'(bus.addr_ptr), 32'h11);

    // Probe during busy must NACK
    probe(ack_n);
    check("t2_probe_busy_nack", 32'(ack_n), 32'd1);
    for (int i = 0; i < 60000 && bus.busy === 1'b1; i++) tick(1);
    check("t2_busy_fell", 32'(bus.busy), 32'd0);
    tick(2);
    check("t1_busy_len", 32'(busy_last), 32'd50000);
    probe(ack_n);
    check("t2_probe_idle_ack", 32'(ack_n), 32'd0);
    tick(4);
    check("t2_no_busy_after_probe", 32'(bus.busy), 32'd0);

    // Table of single-byte writes; reset between them cuts the busy window short
    for (int k = 0; k < 7; k++) begin
      wp = vecs[k].wp;
      if (vecs[k].exp_commit) exp_wr_q.push_back({vecs[k].exp_wr_addr, vecs[k].data});
      i2c_write(vecs[k].word_addr, 1, vecs[k].data, 8'h00, 8'h00);
      tick(4);
      check("vec_busy", 32'(bus.busy), 32'(vecs[k].exp_commit));
      check("vec_ptr", 32'(bus.addr_ptr), 32'(vecs[k].exp_ptr));
      wp = 1'b0;
      pulse_rst();
      check("vec_rst_busy", 32'(bus.busy), 32'd0);
    end

    // Page rollover: 0x1E, 0x1F, then back to 0x00
    exp_wr_q.push_back({8'h1E, 8'hD1});
    exp_wr_q.push_back({8'h1F, 8'hD2});
    exp_wr_q.push_back({8'h00, 8'hD3});
    i2c_write(16'h001E, 3, 8'hD1, 8'hD2, 8'hD3);
    tick(4);
    check("pw_ptr", 32'(bus.addr_ptr), 32'h01);
    pulse_rst();

    // Random + sequential read
    exp_rd_q.push_back(8'h11);
    exp_rd_q.push_back(8'h22);
    exp_rd_q.push_back(8'h33);
    i2c_rand_read(16'h0020, 3);
    tick(4);
    check("t3_ptr", 32'(bus.addr_ptr), 32'h23);
    check("t3_no_busy", 32'(bus.busy), 32'd0);

    // Write-protected byte left the old value in place
    exp_rd_q.push_back(8'h3C);
    i2c_rand_read(16'h0040, 1);

    // Read pointer wraps 0xFF -> 0x00
    exp_rd_q.push_back(8'h99);
    exp_rd_q.push_back(8'hD3);
    i2c_rand_read(16'h00FF, 2);
    tick(2);
    check("wrap_ptr", 32'(bus.addr_ptr), 32'h01);

    // Upper word-address bits ignored
    exp_rd_q.push_back(8'hA5);
    i2c_rand_read(16'hAB55, 1);

    // Wrong device address
    i2c_start();
    write_byte(8'hA0, ack_n);
    check("t6_wrong_addr_nack", 32'(ack_n), 32'd1);
    i2c_stop();

    // Reset while the DUT drives a read data bit low
    i2c_start();
    write_byte(8'hAE, ack_n);
    write_byte(8'h00, ack_n);
    write_byte(8'h10, ack_n);
    i2c_start();
    write_byte(8'hAF, ack_n);
    check("t6_rd_dev_ack", 32'(ack_n), 32'd0);
    sda_m = 1'b1; tick(Q);
    scl   = 1'b1; tick(Q);
    check("t6_rd_bit7_low", 32'(bus.sda_oen), 32'd0);
    rst = 1'b1;
    tick(1);
    check("t6_rst_sda_oen", 32'(bus.sda_oen), 32'd1);
    check("t6_rst_ptr", 32'(bus.addr_ptr), 32'd0);
    rst = 1'b0;
    tick(Q);
    scl = 1'b0; tick(Q);
    v = 8'h00;
    for (int i = 6; i >= 0; i--) bit_in(v[i]);
    v[7] = 1'b1;
    check("t6_released_after_rst", 32'(v), 32'hFF);
    i2c_stop();
    tick(4);

    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
- I2C target (responder) modelling a 24Cxx-style EEPROM with 16-bit word addressing.
- Answers the team's EEPROM master on the same open-drain SCL/SDA pair.
- Supports byte/page write, random read, current-address read and sequential read, plus a write-cycle busy window during which it NACKs its device address.
- Used as the on-chip/bench counterpart for master bring-up.

Parameters:
- DEV_ADDR, 7'b1010111, 7-bit device address matched after START.
- MEM_AW, 8, implemented memory address width (depth 2^MEM_AW bytes); upper word-address bits ignored.
- PAGE_AW, 5, page size 2^PAGE_AW bytes; write pointer wraps inside the page.
- TWR_CYCLES, 50000, clk cycles of write-cycle busy time after a write STOP.

Ports:
- clk  in  1  system clock; SCL period ≥ 8 clk.
- rst  in  1  synchronous active-high reset.
- scl_in  in  1  SCL line level.
- sda_in  in  1  SDA line level.
- wp_pin  in  1  write protect; 1 blocks memory writes.
- sda_oen  out  1  SDA drive enable, active low (0 = pull low, 1 = release).
- busy  out  1  write cycle in progress.
- mem_wr  out  1  one-clk pulse per byte committed to memory.
- mem_wr_addr  out  MEM_AW  address of committed byte.
- mem_wr_data  out  8  committed byte.
- addr_ptr  out  MEM_AW  current internal address pointer.

Behaviour:
- Reset (rst=1 at posedge clk): sda_oen=1, busy=0, mem_wr=0, mem_wr_addr=0, mem_wr_data=0, addr_ptr=0, state IDLE, busy counter 0. Memory array contents are not reset.
- Line sampling:
  - scl_in/sda_in pass through 2-flop synchronizers.
  - Edges are detected on the synchronized values; all actions below refer to synchronized edges.
  - SCL rising: sample a bit.
  - SCL falling: change sda_oen; sda_oen never changes while synchronized SCL is high.
- Bus conditions:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Both are recognised in every state and take priority.
  - START (incl. repeated): go to DEV, bit counter 0, release SDA.
  - STOP: go to IDLE, release SDA.
- States:
  - IDLE: wait for START.
  - DEV: shift 8 bits MSB first. On the 8th bit, if addr[7:1]==DEV_ADDR and busy==0, ACK; otherwise NACK (release SDA) and go to IDLE.
  - ACK phase (common): drive sda_oen=0 on the SCL falling edge after bit 8; release on the next SCL falling edge; then continue to the next state.
  - After DEV ACK: R/W=0 goes to WAH; R/W=1 goes to RD.
  - WAH: receive high address byte, ACK, go to WAL.
  - WAL: receive low address byte, ACK, load addr_ptr with its low MEM_AW bits, go to WD.
  - WD: receive data byte, ACK, then:
    - If wp_pin=0: write mem[addr_ptr]; pulse mem_wr for 1 clk with addr/data; set the write-pending flag.
    - If wp_pin=1: byte is ACKed but not written.
    - Advance addr_ptr[PAGE_AW-1:0] modulo page size; upper bits unchanged.
    - Stay in WD.
  - RD:
    - Load shift register from mem[addr_ptr] at DEV ACK release (or after the previous master ACK).
    - Drive bits MSB first on SCL falling edges.
    - After bit 8, release SDA and sample the master ACK on the 9th SCL rising edge.
    - addr_ptr increments modulo 2^MEM_AW once per byte sent.
    - Master ACK (0): send the next byte.
    - Master NACK (1): go to IDLE with SDA released.
- Write cycle:
  - STOP with write-pending set sets busy=1 for exactly TWR_CYCLES clk, then busy=0, and clears pending.
  - START/STOP without data bytes (e.g. the dummy write of a random read) does not start busy.
  - Repeated START clears pending; the bytes already written remain written.
- Boundary conditions:
  - Word-address bits above MEM_AW are ignored.
  - Page rollover overwrites from the page start.
  - Read pointer wraps from 2^MEM_AW-1 to 0.
  - A STOP in the middle of a byte discards the partial byte.
  - rst during a transfer returns to IDLE immediately and releases SDA; busy clears.
- The block never drives SCL (no clock stretching).

Test Plan:
1. Byte write: START, 0xAE, 0x00, 0x10, 0x5A, STOP -> ACK on all four bytes; mem_wr pulse with addr 0x10, data 0x5A; busy high for 50000 clk.
2. Busy poll: START, 0xAE during busy -> NACK, SDA stays released. Same probe after busy falls -> ACK.
3. Random + sequential read after writing 0x11,0x22,0x33 at 0x20..0x22: dummy write to 0x0020, repeated START, 0xAF -> bytes 0x11, 0x22 (master ACK), then 0x33 with master NACK, STOP -> addr_ptr=0x23, busy stays 0.
4. Page wrap: write 3 bytes starting at 0x1E with PAGE_AW=5 -> commits at 0x1E, 0x1F, 0x00.
5. wp_pin=1 write of 0x77 to 0x40 -> all bytes ACKed, no mem_wr pulse, busy not asserted; read of 0x40 returns the prior value.
6. Wrong address 0xA0 -> NACK. Separately, rst asserted mid-read -> sda_oen=1 next clk, state IDLE.
